multi_alarm_controller: RTL
===========================

MULTI_ALARM_CONTROLLER -- requirements
Module: multi_alarm_controller

Interface
REQ-001 Parameter N_ALARMS, default 4, number of independent alarm channels, legal range 1..8.
REQ-002 Parameter TIME_W, default 16, width of one time word (BCD HH:MM).
REQ-003 Parameter SNOOZE_MIN, default 9, snooze length in minutes, legal range 1..255.
REQ-004 Parameter RING_TIMEOUT_MIN, default 60, minutes of unattended ringing before auto-stop, legal range 1..255.
REQ-005 i_Clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 i_Rst_N  in  1  reset; synchronous and active-low.
REQ-007 i_Change_Time  in  1  time-set button level.
REQ-008 i_Change_Alarm  in  1  alarm-set button level.
REQ-009 i_Alarm_Sel  in  3  index of the alarm being edited or displayed; values >= N_ALARMS are treated as 0.
REQ-010 i_Minute_Tick  in  1  one-cycle pulse at each minute rollover of the time-of-day counter.
REQ-011 i_Snooze  in  1  one-cycle snooze request.
REQ-012 i_Dismiss  in  1  one-cycle dismiss request.
REQ-013 i_Alarm_Enables  in  N_ALARMS  per-channel enable level.
REQ-014 i_Time  in  TIME_W  current time of day.
REQ-015 i_Alarm_Times  in  N_ALARMS*TIME_W  packed alarm times; channel k occupies bits [k*TIME_W +: TIME_W].
REQ-016 o_Display_Sel  out  1  0 = show time, 1 = show the alarm selected by o_Display_Idx.
REQ-017 o_Display_Idx  out  3  registered copy of the sanitised i_Alarm_Sel.
REQ-018 o_Ringing  out  N_ALARMS  per-channel ringing flag.
REQ-019 o_Alarm_On  out  1  OR of o_Ringing; drives the buzzer.
REQ-020 o_Snoozed  out  1  high while any channel is in SNOOZED.
REQ-021 o_Alarm_Enabled  out  N_ALARMS  combinational pass-through of i_Alarm_Enables.

Function
REQ-022 o_Display_Sel SHALL be registered high exactly when i_Change_Alarm=1 and i_Change_Time=0 in the previous cycle; otherwise it is low. o_Display_Idx SHALL update on the same edge.
REQ-023 Each channel SHALL run the FSM IDLE / RINGING / SNOOZED with a registered match flag and an 8-bit minute counter.
REQ-024 A channel SHALL trigger only on the rising edge of its match (i_Time == alarm time, with the channel enabled), so a dismissed alarm does not re-ring within the same minute.
REQ-025 IDLE -> RINGING on trigger; the minute counter is cleared. RINGING shall be visible on o_Ringing one cycle after the match edge.
REQ-026 RINGING -> IDLE on i_Dismiss; -> SNOOZED on i_Snooze with the counter loaded to SNOOZE_MIN; -> IDLE when the counter reaches RING_TIMEOUT_MIN on an i_Minute_Tick.
REQ-027 SNOOZED: the counter decrements on each i_Minute_Tick. When the counter is 1 and a tick arrives, the channel goes to RINGING and the counter is cleared. i_Dismiss sends the channel to IDLE. A match edge is ignored.
REQ-028 i_Snooze and i_Dismiss SHALL act on every channel currently in RINGING; i_Dismiss also acts on SNOOZED channels.
REQ-029 Simultaneous events: dismiss beats snooze; dismiss beats trigger; snooze beats tick (full reload); timeout and snooze in the same cycle gives SNOOZED.
REQ-030 Deasserting a channel's enable SHALL force that channel to IDLE on the next edge, whatever its state.
REQ-031 Counters SHALL saturate and never wrap. Comparisons SHALL use the full TIME_W width.

Reset
REQ-032 While i_Rst_N=0 at an edge, every channel SHALL go to IDLE with counter and match flag cleared. o_Display_Sel, o_Display_Idx, o_Ringing, o_Alarm_On and o_Snoozed SHALL all be 0.
REQ-033 A match already present when reset releases SHALL NOT trigger a channel; the match flag is reloaded on the first edge after reset.
REQ-034 Reset asserted mid-ring or mid-snooze SHALL take effect on that same edge.

Configuration
REQ-035 Macro ALARM_SNOOZE_EN: when defined, snooze behaves as specified above.
REQ-036 When ALARM_SNOOZE_EN is undefined, i_Snooze SHALL be ignored, SNOOZED SHALL be unreachable, and o_Snoozed SHALL be tied to 0.

Structure
REQ-037 Package alarm_pkg SHALL hold the FSM state typedef (IDLE, RINGING, SNOOZED), the counter width constant (8) and the alarm-select width constant (3).
REQ-038 Per-channel logic SHALL live in sub-module alarm_channel, instantiated N_ALARMS times by generate. The top level holds the display register and the OR/pass-through outputs.

Verification
REQ-039 Trigger: channel 1 time = 16'h0730, enabled; i_Time goes 0729 -> 0730 -> o_Ringing=4'b0010 and o_Alarm_On=1 one cycle later.
REQ-040 No re-ring: dismiss while i_Time stays 0730 -> o_Ringing=0 for the rest of that minute.
REQ-041 Snooze: pulse i_Snooze during ringing, then send 9 ticks -> o_Snoozed=1 through tick 8, and o_Ringing=4'b0010 after tick 9.
REQ-042 Timeout: ring with no user action for 60 ticks -> channel returns to IDLE after tick 60.
REQ-043 Simultaneous: i_Snooze and i_Dismiss in the same cycle -> IDLE. Channels 0 and 2 both matching 0600 -> o_Ringing=4'b0101, and one dismiss clears both.
REQ-044 Reset: i_Rst_N=0 while snoozed -> all outputs 0 on the next edge; with i_Time held equal to an alarm time through reset release, no ring occurs.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-alarm controller.
package alarm_pkg;

  // Width of the per-channel minute counter.
  localparam int unsigned CNT_W = 8;
  // Width of the alarm select / display index.
  localparam int unsigned SEL_W = 3;

  // Per-channel FSM state; plain constants keep older tools happy.
  typedef logic [1:0] alarm_state_t;
  localparam alarm_state_t IDLE    = 2'd0;
  localparam alarm_state_t RINGING = 2'd1;
  localparam alarm_state_t SNOOZED = 2'd2;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: edge-triggered match, ring timeout and optional snooze.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned TIME_W           = 16,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 60
) (
  input  logic              i_Clk,
  input  logic              i_Rst_N,
  input  logic              i_Enable,
  input  logic [TIME_W-1:0] i_Time,
  input  logic [TIME_W-1:0] i_Alarm_Time,
  input  logic              i_Minute_Tick,
  input  logic              i_Snooze,
  input  logic              i_Dismiss,
  output logic              o_Ringing,
  output logic              o_Snoozed
);

  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  // Low for the first edge after reset so a standing match cannot trigger.
  logic             armed_q;
  logic             trigger;
  logic [CNT_W-1:0] cnt_inc;

`ifndef ALARM_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = i_Snooze;
`endif

  // Next-state logic for the channel FSM and minute counter.
  always_comb begin
    match_d = i_Enable && (i_Time == i_Alarm_Time);
    trigger = armed_q && match_d && !match_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_Enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger && !i_Dismiss) begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end
        RINGING: begin
          if (i_Dismiss) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
          end else if (i_Snooze) begin
            state_d = SNOOZED;
            cnt_d   = CNT_W'(SNOOZE_MIN);
`endif
          end else if (i_Minute_Tick) begin
            if (cnt_inc >= CNT_W'(RING_TIMEOUT_MIN)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (i_Dismiss) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (i_Minute_Tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = RINGING;
              cnt_d   = '0;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      armed_q <= 1'b1;
    end
  end

  assign o_Ringing = (state_q == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign o_Snoozed = (state_q == SNOOZED);
`else
  assign o_Snoozed = 1'b0;
`endif

endmodule

// File: rtl/multi_alarm_controller.sv
// Multi-channel alarm controller: display select register plus N_ALARMS
// independent alarm channels. Snooze is enabled by defining ALARM_SNOOZE_EN.
module multi_alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned N_ALARMS         = 4,
  parameter int unsigned TIME_W           = 16,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 60
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_N,
  input  logic                       i_Change_Time,
  input  logic                       i_Change_Alarm,
  input  logic [SEL_W-1:0]           i_Alarm_Sel,
  input  logic                       i_Minute_Tick,
  input  logic                       i_Snooze,
  input  logic                       i_Dismiss,
  input  logic [N_ALARMS-1:0]        i_Alarm_Enables,
  input  logic [TIME_W-1:0]          i_Time,
  input  logic [N_ALARMS*TIME_W-1:0] i_Alarm_Times,
  output logic                       o_Display_Sel,
  output logic [SEL_W-1:0]           o_Display_Idx,
  output logic [N_ALARMS-1:0]        o_Ringing,
  output logic                       o_Alarm_On,
  output logic                       o_Snoozed,
  output logic [N_ALARMS-1:0]        o_Alarm_Enabled
);

  logic             display_sel_q, display_sel_d;
  logic [SEL_W-1:0] display_idx_q, display_idx_d;
  logic [N_ALARMS-1:0] snoozed;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    display_sel_d = i_Change_Alarm && !i_Change_Time;
    display_idx_d = (32'(i_Alarm_Sel) >= N_ALARMS) ? '0 : i_Alarm_Sel;
  end

  // Display select/index registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      display_sel_q <= 1'b0;
      display_idx_q <= '0;
    end else begin
      display_sel_q <= display_sel_d;
      display_idx_q <= display_idx_d;
    end
  end

  for (genvar k = 0; k < N_ALARMS; k++) begin : g_ch
    alarm_channel #(
      .TIME_W          (TIME_W),
      .SNOOZE_MIN      (SNOOZE_MIN),
      .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN)
    ) u_channel (
      .i_Clk        (i_Clk),
      .i_Rst_N      (i_Rst_N),
      .i_Enable     (i_Alarm_Enables[k]),
      .i_Time       (i_Time),
      .i_Alarm_Time (i_Alarm_Times[k*TIME_W +: TIME_W]),
      .i_Minute_Tick(i_Minute_Tick),
      .i_Snooze     (i_Snooze),
      .i_Dismiss    (i_Dismiss),
      .o_Ringing    (o_Ringing[k]),
      .o_Snoozed    (snoozed[k])
    );
  end

  assign o_Display_Sel   = display_sel_q;
  assign o_Display_Idx   = display_idx_q;
  assign o_Alarm_On      = |o_Ringing;
  assign o_Snoozed       = |snoozed;
  assign o_Alarm_Enabled = i_Alarm_Enables;

endmodule
